// File: rtl/mux16x1.sv
// 16-to-1 single-bit multiplexer with a combinational output and a registered copy.
// The select is assembled from four scalar lines, sel3 being the most significant.
`timescale 1ns/1ps

module mux16x1 (
  input  logic clk,
  input  logic rst_n,
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic i4,
  input  logic i5,
  input  logic i6,
  input  logic i7,
  input  logic i8,
  input  logic i9,
  input  logic i10,
  input  logic i11,
  input  logic i12,
  input  logic i13,
  input  logic i14,
  input  logic i15,
  input  logic sel3,
  input  logic sel2,
  input  logic sel1,
  input  logic sel0,
  output logic y_out,
  output logic y_q
);

  logic [15:0] dataVec;
  logic [3:0]  selIdx;
  logic        yQ_d;
  logic        yQ_q;

  assign dataVec = {i15, i14, i13, i12, i11, i10, i9, i8,
                    i7,  i6,  i5,  i4,  i3,  i2,  i1, i0};
  assign selIdx  = {sel3, sel2, sel1, sel0};

  // An X/Z select bit makes the indexed read return X, so no input is ever picked silently.
  assign y_out = dataVec[selIdx];

  assign yQ_d = y_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yQ_q <= 1'b0;
    end else begin
      yQ_q <= yQ_d;
    end
  end

  assign y_q = yQ_q;

endmodule

// File: tb/tb_mux16x1.sv
// Self-checking bench for mux16x1: vector table, random vectors, registered-path,
// async reset sequences and a free-running toggle soak against a bit-shift reference model.
`timescale 1ns/1ps

module tb_mux16x1;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  sel;
    logic        expY;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] data;
  logic [3:0]  sel;
  logic        y_out;
  logic        y_q;
  int          checks;
  int          failures;
  bit          soakOn;
  vec_t        vecs[$];

  mux16x1 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .i0   (data[0]),
    .i1   (data[1]),
    .i2   (data[2]),
    .i3   (data[3]),
    .i4   (data[4]),
    .i5   (data[5]),
    .i6   (data[6]),
    .i7   (data[7]),
    .i8   (data[8]),
    .i9   (data[9]),
    .i10  (data[10]),
    .i11  (data[11]),
    .i12  (data[12]),
    .i13  (data[13]),
    .i14  (data[14]),
    .i15  (data[15]),
    .sel3 (sel[3]),
    .sel2 (sel[2]),
    .sel1 (sel[1]),
    .sel0 (sel[0]),
    .y_out(y_out),
    .y_q  (y_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the selected input is the bit at position s of the packed input word.
  function automatic logic refMux(input logic [15:0] d, input logic [3:0] s);
    logic [15:0] shifted;
    shifted = d >> s;
    return shifted[0];
  endfunction

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] s);
    data = d;
    sel  = s;
  endtask

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b (data=%h sel=%0d t=%0t)",
               name, act, exp, data, sel, $time);
    end
  endtask

  task automatic toggler(input int idx, input int period);
    while (soakOn) begin
      #(period);
      if (soakOn) begin
        if (idx < 16) data[idx] = ~data[idx];
        else          sel[idx-16] = ~sel[idx-16];
      end
    end
  endtask

  initial begin
    vec_t        v;
    logic        bitVal;
    logic [3:0]  s;
    logic [15:0] d;
    checks   = 0;
    failures = 0;
    soakOn   = 1'b0;

    // Table: one-hot sweep, walking-zero sweep and select bit order.
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) begin
        v.data = 16'h0001 << k;
        v.sel  = 4'(j);
        v.expY = (j == k);
        vecs.push_back(v);
        v.data = ~(16'h0001 << k);
        v.expY = (j != k);
        vecs.push_back(v);
      end
    end
    v.data = 16'h0020; v.sel = 4'b0101; v.expY = 1'b1; vecs.push_back(v);
    v.data = 16'h0020; v.sel = 4'b1010; v.expY = 1'b0; vecs.push_back(v);

    // Reset state, with the combinational path live during reset.
    rst_n = 1'b0;
    applyStimulus(16'h0080, 4'd7);
    #1;
    checkOutput("reset_yq", y_q, 1'b0);
    checkOutput("reset_yout_valid", y_out, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("reset_yq_held", y_q, 1'b0);

    foreach (vecs[n]) begin
      applyStimulus(vecs[n].data, vecs[n].sel);
      #1;
      checkOutput("table_yout", y_out, vecs[n].expY);
    end

    for (int n = 0; n < 64; n++) begin
      d = 16'($urandom);
      s = 4'($urandom_range(0, 15));
      applyStimulus(d, s);
      #1;
      checkOutput("random_yout", y_out, refMux(d, s));
    end

    // Registered path: toggle i3 between edges with s = 3.
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'h0000, 4'd3);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      bitVal = 1'($urandom);
      data[3] = bitVal;
      @(posedge clk);
      #1;
      checkOutput("regpath_yq", y_q, bitVal);
      data[3] = ~bitVal;
      #1;
      checkOutput("regpath_yout", y_out, ~bitVal);
      checkOutput("regpath_yq_hold", y_q, bitVal);
    end

    // Async reset mid-cycle, then release and reload.
    @(negedge clk);
    applyStimulus(16'h0400, 4'd10);
    @(posedge clk);
    #1;
    checkOutput("async_pre_yq", y_q, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #0.5;
    checkOutput("async_yq_clear", y_q, 1'b0);
    checkOutput("async_yout_live", y_out, 1'b1);
    #0.5;
    rst_n = 1'b1;
    #0.5;
    checkOutput("release_yq_waits", y_q, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("release_first_edge", y_q, 1'b1);

    // Reset falling on the same instant as a rising clock edge.
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("simul_edge_yq", y_q, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Soak: every input and select line toggles at its own period (5..100 ns).
    @(negedge clk);
    applyStimulus(16'h0000, 4'd0);
    soakOn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      fork
        automatic int idx = i;
        toggler(idx, 5 + 5 * idx);
      join_none
    end
    for (int t = 0; t < 1000; t++) begin
      #0.5;
      if (t % 2 == 0) checkOutput("soak_yout", y_out, refMux(data, sel));
    end
    soakOn = 1'b0;
    #110;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
